// File: rtl/ppwm_multi_pkg.sv
// ---------------------------------------------------------------------------
// ppwm_multi_pkg
// Shared types and helpers for the multi-channel programmable PWM core.
//   rx_state_e : states of the serial frame receiver
//   frame_len  : total frame length in bits (start + index + value + stop)
// ---------------------------------------------------------------------------
package ppwm_multi_pkg;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_IDX,
        RX_VAL,
        RX_STOP
    } rx_state_e;

    function automatic int frame_len(input int ch_idx_w, input int cnt_w);
        return 1 + ch_idx_w + cnt_w + 1;
    endfunction

endpackage

// File: rtl/ppwm_rx.sv
// ---------------------------------------------------------------------------
// ppwm_rx
// Serial frame receiver. The line idles low; a frame is
//   start(1) | channel index (CH_IDX_WIDTH, MSB first) |
//   value (COUNTER_WIDTH, MSB first) | stop(0)
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   data_i     : serial line, one bit per clock
//   wr_valid   : one-cycle pulse in the cycle after an accepted stop bit
//   wr_idx     : channel index of the frame (valid with wr_valid)
//   wr_value   : compare value of the frame (valid with wr_valid)
//   err        : one-cycle pulse in the cycle after a rejected stop bit
// ---------------------------------------------------------------------------
module ppwm_rx
    import ppwm_multi_pkg::*;
#(
    parameter  int NUM_CH        = 4,
    parameter  int COUNTER_WIDTH = 10,
    localparam int CH_IDX_WIDTH  = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     data_i,
    output logic                     wr_valid,
    output logic [CH_IDX_WIDTH-1:0]  wr_idx,
    output logic [COUNTER_WIDTH-1:0] wr_value,
    output logic                     err
);

    localparam int SH_W   = CH_IDX_WIDTH + COUNTER_WIDTH;
    localparam int BCNT_W = $clog2(frame_len(CH_IDX_WIDTH, COUNTER_WIDTH));
    localparam logic [CH_IDX_WIDTH:0] NUM_CH_L = (CH_IDX_WIDTH + 1)'(NUM_CH);

    rx_state_e         r_state;
    rx_state_e         w_state_nxt;
    logic [BCNT_W-1:0] r_bcnt;
    logic [BCNT_W-1:0] w_bcnt_nxt;
    logic [SH_W-1:0]   r_shift;
    logic [SH_W-1:0]   w_shift_nxt;
    logic              r_wr_valid;
    logic              r_err;
    logic              w_accept;
    logic              w_reject;
    logic              w_idx_ok;

    // Index and value share one shift register; after SH_W shifts it holds
    // exactly {idx, value}. It is left untouched in IDLE/STOP, so it stays
    // stable during the wr_valid cycle even if the next frame starts then.
    assign w_idx_ok = ({1'b0, r_shift[SH_W-1 -: CH_IDX_WIDTH]} < NUM_CH_L);

    always_comb begin
        w_state_nxt = r_state;
        w_bcnt_nxt  = r_bcnt;
        w_shift_nxt = r_shift;
        w_accept    = 1'b0;
        w_reject    = 1'b0;
        case (r_state)
            RX_IDLE: begin
                if (data_i) begin
                    w_state_nxt = RX_IDX;
                    w_bcnt_nxt  = '0;
                end
            end
            RX_IDX: begin
                w_shift_nxt = {r_shift[SH_W-2:0], data_i};
                if (r_bcnt == BCNT_W'(CH_IDX_WIDTH - 1)) begin
                    w_state_nxt = RX_VAL;
                    w_bcnt_nxt  = '0;
                end else begin
                    w_bcnt_nxt = r_bcnt + 1'b1;
                end
            end
            RX_VAL: begin
                w_shift_nxt = {r_shift[SH_W-2:0], data_i};
                if (r_bcnt == BCNT_W'(COUNTER_WIDTH - 1)) begin
                    w_state_nxt = RX_STOP;
                    w_bcnt_nxt  = '0;
                end else begin
                    w_bcnt_nxt = r_bcnt + 1'b1;
                end
            end
            RX_STOP: begin
                w_state_nxt = RX_IDLE;
                if (!data_i && w_idx_ok) begin
                    w_accept = 1'b1;
                end else begin
                    w_reject = 1'b1;
                end
            end
            default: begin
                w_state_nxt = RX_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= RX_IDLE;
            r_bcnt     <= '0;
            r_wr_valid <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_bcnt     <= w_bcnt_nxt;
            r_wr_valid <= w_accept;
            r_err      <= w_reject;
        end
    end

    // Payload only; qualified by r_wr_valid, so it needs no reset.
    always_ff @(posedge clk) begin
        r_shift <= w_shift_nxt;
    end

    assign wr_valid = r_wr_valid;
    assign err      = r_err;
    assign wr_idx   = r_shift[SH_W-1 -: CH_IDX_WIDTH];
    assign wr_value = r_shift[COUNTER_WIDTH-1:0];

endmodule

// File: rtl/ppwm_multi.sv
// ---------------------------------------------------------------------------
// ppwm_multi
// Multi-channel programmable PWM. One shared period counter drives NUM_CH
// compare channels; each channel has a shadow compare value written over a
// serial line and an active value loaded from the shadow once per period.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   data_i         : serial programming line (see ppwm_rx)
//   pwm_o          : PWM outputs, bit i = channel i, high while cnt < active[i]
//   period_start_o : one-cycle pulse in the first cycle of each period
//   cfg_done_o     : one-cycle pulse when a frame is accepted
//   cfg_err_o      : one-cycle pulse when a frame is discarded
// Build option:
//   PPWM_CENTER_ALIGN_EN : up/down (center-aligned) counting, period 2*MAX;
//                          shadow load at cnt==1 while counting down.
//                          Undefined: edge-aligned, period 2**COUNTER_WIDTH.
// ---------------------------------------------------------------------------
module ppwm_multi
    import ppwm_multi_pkg::*;
#(
    parameter  int NUM_CH        = 4,
    parameter  int COUNTER_WIDTH = 10,
    localparam int CH_IDX_WIDTH  = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              data_i,
    output logic [NUM_CH-1:0] pwm_o,
    output logic              period_start_o,
    output logic              cfg_done_o,
    output logic              cfg_err_o
);

    localparam logic [COUNTER_WIDTH-1:0] CNT_MAX = '1;

    logic [COUNTER_WIDTH-1:0] r_cnt;
    logic                     r_pstart;
    logic [COUNTER_WIDTH-1:0] r_shadow [NUM_CH];
    logic [COUNTER_WIDTH-1:0] r_active [NUM_CH];
    logic                     w_load;
    logic [NUM_CH-1:0]        w_hit;
    logic [NUM_CH-1:0]        w_pwm;
    logic                     w_wr_valid;
    logic [CH_IDX_WIDTH-1:0]  w_wr_idx;
    logic [COUNTER_WIDTH-1:0] w_wr_value;
    logic                     w_err;

    ppwm_rx #(
        .NUM_CH        (NUM_CH),
        .COUNTER_WIDTH (COUNTER_WIDTH)
    ) u_rx (
        .clk      (clk),
        .rst      (rst),
        .data_i   (data_i),
        .wr_valid (w_wr_valid),
        .wr_idx   (w_wr_idx),
        .wr_value (w_wr_value),
        .err      (w_err)
    );

`ifdef PPWM_CENTER_ALIGN_EN
    localparam logic [COUNTER_WIDTH-1:0] CNT_ONE = COUNTER_WIDTH'(1);

    // r_dir: 0 = counting up, 1 = counting down
    logic r_dir;

    assign w_load = r_dir && (r_cnt == CNT_ONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_dir    <= 1'b0;
            r_pstart <= 1'b0;
        end else begin
            // The cycle after the last down-count step is cnt==0.
            r_pstart <= w_load;
            if (!r_dir) begin
                if (r_cnt == CNT_MAX) begin
                    r_dir <= 1'b1;
                    r_cnt <= CNT_MAX - 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                if (r_cnt == CNT_ONE) begin
                    r_dir <= 1'b0;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt - 1'b1;
                end
            end
        end
    end
`else
    assign w_load = (r_cnt == CNT_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_pstart <= 1'b0;
        end else begin
            // Registered wrap detect lands exactly on the cnt==0 cycle; the
            // post-reset cnt==0 cycle has no pulse because no wrap preceded it.
            r_pstart <= w_load;
            r_cnt    <= r_cnt + 1'b1;
        end
    end
`endif

    always_comb begin
        w_hit = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_hit[i] = w_wr_valid && (w_wr_idx == CH_IDX_WIDTH'(i));
        end
    end

    // A frame landing on the load cycle goes straight to active, so it is
    // not lost behind the stale shadow value.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_shadow[i] <= '0;
                r_active[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_hit[i]) begin
                    r_shadow[i] <= w_wr_value;
                end
                if (w_load) begin
                    r_active[i] <= w_hit[i] ? w_wr_value : r_shadow[i];
                end
            end
        end
    end

    always_comb begin
        w_pwm = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_pwm[i] = (r_cnt < r_active[i]);
        end
    end

    assign pwm_o          = w_pwm;
    assign period_start_o = r_pstart;
    assign cfg_done_o     = w_wr_valid;
    assign cfg_err_o      = w_err;

endmodule

// File: tb/tb_ppwm_multi.sv
// ---------------------------------------------------------------------------
// tb_ppwm_multi
// Self-checking bench for ppwm_multi with NUM_CH=4, COUNTER_WIDTH=4.
// The reference model works at frame/period level: the counter value is a
// function of the cycle number since reset release, frames are known by
// their (idx, value, stop) fields, and active values are refreshed from the
// shadow array once per period.
// ---------------------------------------------------------------------------
module tb_ppwm_multi;

    localparam int NUM_CH = 4;
    localparam int CW     = 4;
    localparam int MAXV   = 15;
`ifdef PPWM_CENTER_ALIGN_EN
    localparam int PERIOD = 2 * MAXV;
`else
    localparam int PERIOD = MAXV + 1;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              data_i;
    logic [NUM_CH-1:0] pwm_o;
    logic              period_start_o;
    logic              cfg_done_o;
    logic              cfg_err_o;

    always #5 clk = ~clk;

    ppwm_multi #(
        .NUM_CH        (NUM_CH),
        .COUNTER_WIDTH (CW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .data_i         (data_i),
        .pwm_o          (pwm_o),
        .period_start_o (period_start_o),
        .cfg_done_o     (cfg_done_o),
        .cfg_err_o      (cfg_err_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    int t;
    int m_shadow [NUM_CH];
    int m_active [NUM_CH];
    bit exp_done, exp_err, nxt_done, nxt_err;
    int wr_idx, wr_val, nxt_idx, nxt_val;

    // observation counters, cleared by the tests
    int obs_done, obs_err, obs_pstart;
    int obs_high [NUM_CH];

    function automatic int model_cnt(input int tt);
`ifdef PPWM_CENTER_ALIGN_EN
        int p;
        p = tt % PERIOD;
        return (p <= MAXV) ? p : (PERIOD - p);
`else
        return tt % PERIOD;
`endif
    endfunction

    function automatic bit is_load(input int tt);
        return (tt % PERIOD) == (PERIOD - 1);
    endfunction

    // cycles per period that a channel with compare value v is high
    function automatic int exp_high(input int v);
`ifdef PPWM_CENTER_ALIGN_EN
        return (v == 0) ? 0 : (2 * v - 1);
`else
        return v;
`endif
    endfunction

    task automatic clear_obs();
        obs_done   = 0;
        obs_err    = 0;
        obs_pstart = 0;
        for (int i = 0; i < NUM_CH; i++) obs_high[i] = 0;
    endtask

    task automatic model_reset();
        t = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            m_shadow[i] = 0;
            m_active[i] = 0;
        end
        exp_done = 0; exp_err = 0; nxt_done = 0; nxt_err = 0;
        wr_idx = 0; wr_val = 0; nxt_idx = 0; nxt_val = 0;
    endtask

    task automatic do_reset(input int n);
        rst    = 1'b1;
        data_i = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    // One clock: drive a bit, compare outputs with the model mid-cycle,
    // then advance the model past the rising edge.
    task automatic step(input logic d);
        logic [NUM_CH-1:0] e_pwm;
        logic              e_ps;
        data_i = d;
        @(negedge clk);
        for (int i = 0; i < NUM_CH; i++) e_pwm[i] = (model_cnt(t) < m_active[i]);
        e_ps = (t > 0) && ((t % PERIOD) == 0);
        n_checks += 4;
        if (pwm_o !== e_pwm) begin
            n_fail++;
            $display("FAIL pwm t=%0d got %b want %b", t, pwm_o, e_pwm);
        end
        if (period_start_o !== e_ps) begin
            n_fail++;
            $display("FAIL period_start t=%0d got %b want %b", t, period_start_o, e_ps);
        end
        if (cfg_done_o !== exp_done) begin
            n_fail++;
            $display("FAIL cfg_done t=%0d got %b want %b", t, cfg_done_o, exp_done);
        end
        if (cfg_err_o !== exp_err) begin
            n_fail++;
            $display("FAIL cfg_err t=%0d got %b want %b", t, cfg_err_o, exp_err);
        end
        if (cfg_done_o === 1'b1) obs_done++;
        if (cfg_err_o === 1'b1) obs_err++;
        if (period_start_o === 1'b1) obs_pstart++;
        for (int i = 0; i < NUM_CH; i++) if (pwm_o[i] === 1'b1) obs_high[i]++;
        @(posedge clk);
        #1;
        if (exp_done) m_shadow[wr_idx] = wr_val;
        if (is_load(t)) for (int i = 0; i < NUM_CH; i++) m_active[i] = m_shadow[i];
        exp_done = nxt_done; exp_err = nxt_err;
        wr_idx = nxt_idx; wr_val = nxt_val;
        nxt_done = 0; nxt_err = 0;
        t++;
    endtask

    task automatic send_frame(input logic [1:0] idx, input logic [CW-1:0] val,
                              input logic stop);
        step(1'b1);
        for (int b = 1; b >= 0; b--) step(idx[b]);
        for (int b = CW - 1; b >= 0; b--) step(val[b]);
        nxt_done = !stop;
        nxt_err  = stop;
        nxt_idx  = int'(idx);
        nxt_val  = int'(val);
        step(stop);
    endtask

    // Idle until the cycle k cycles before a shadow-load cycle.
    task automatic wait_load_in(input int k);
        int guard;
        guard = 0;
        while (!is_load(t + k) && guard < 2 * PERIOD + 2) begin
            step(1'b0);
            guard++;
        end
        n_checks++;
        if (!is_load(t + k)) begin
            n_fail++;
            $display("FAIL wait_load t=%0d got no load slot want slot within %0d", t, 2 * PERIOD);
        end
    endtask

    task automatic next_period();
        wait_load_in(0);
        step(1'b0);
    endtask

    task automatic test_reset();
        do_reset(3);
        clear_obs();
        repeat (64) step(1'b0);
        n_checks += 2;
        if (obs_pstart !== 63 / PERIOD) begin
            n_fail++;
            $display("FAIL reset_pstart_count got %0d want %0d", obs_pstart, 63 / PERIOD);
        end
        if (obs_high[0] + obs_high[1] + obs_high[2] + obs_high[3] !== 0) begin
            n_fail++;
            $display("FAIL reset_pwm_idle got %0d want 0", obs_high[0] + obs_high[1] + obs_high[2] + obs_high[3]);
        end
    endtask

    task automatic test_single_frame();
        clear_obs();
        send_frame(2'd2, 4'd5, 1'b0);
        next_period();
        n_checks++;
        if (obs_done !== 1) begin
            n_fail++;
            $display("FAIL single_done got %0d want 1", obs_done);
        end
        clear_obs();
        repeat (PERIOD) step(1'b0);
        n_checks += 2;
        if (obs_high[2] !== exp_high(5)) begin
            n_fail++;
            $display("FAIL single_duty got %0d want %0d", obs_high[2], exp_high(5));
        end
        if (obs_high[0] + obs_high[1] + obs_high[3] !== 0) begin
            n_fail++;
            $display("FAIL single_others got %0d want 0", obs_high[0] + obs_high[1] + obs_high[3]);
        end
    endtask

    task automatic test_err_back_to_back();
        clear_obs();
        send_frame(2'd1, 4'd9, 1'b1);
        send_frame(2'd0, 4'd15, 1'b0);
        next_period();
        n_checks += 2;
        if (obs_err !== 1) begin
            n_fail++;
            $display("FAIL b2b_err got %0d want 1", obs_err);
        end
        if (obs_done !== 1) begin
            n_fail++;
            $display("FAIL b2b_done got %0d want 1", obs_done);
        end
        clear_obs();
        repeat (PERIOD) step(1'b0);
        n_checks += 2;
        if (obs_high[0] !== PERIOD - 1) begin
            n_fail++;
            $display("FAIL b2b_ch0_duty got %0d want %0d", obs_high[0], PERIOD - 1);
        end
        if (obs_high[1] !== 0) begin
            n_fail++;
            $display("FAIL b2b_ch1_untouched got %0d want 0", obs_high[1]);
        end
    endtask

    task automatic test_mid_period();
        // frame starts on the load cycle, so its write lands mid-period
        wait_load_in(0);
        clear_obs();
        send_frame(2'd1, 4'd8, 1'b0);
        wait_load_in(0);
        step(1'b0);
        n_checks++;
        if (obs_high[1] !== 0) begin
            n_fail++;
            $display("FAIL mid_current_period got %0d want 0", obs_high[1]);
        end
        clear_obs();
        repeat (PERIOD) step(1'b0);
        n_checks++;
        if (obs_high[1] !== exp_high(8)) begin
            n_fail++;
            $display("FAIL mid_next_period got %0d want %0d", obs_high[1], exp_high(8));
        end
        // write pulse lands exactly on the load cycle
        wait_load_in(8);
        send_frame(2'd1, 4'd3, 1'b0);
        n_checks++;
        if (!is_load(t)) begin
            n_fail++;
            $display("FAIL bypass_timing t=%0d got no load want load", t);
        end
        step(1'b0);
        clear_obs();
        repeat (PERIOD) step(1'b0);
        n_checks++;
        if (obs_high[1] !== exp_high(3)) begin
            n_fail++;
            $display("FAIL bypass_duty got %0d want %0d", obs_high[1], exp_high(3));
        end
    endtask

    task automatic test_rst_mid_frame();
        clear_obs();
        step(1'b1);
        step(1'b1);
        step(1'b0);
        do_reset(1);
        clear_obs();
        repeat (20) step(1'b0);
        n_checks += 3;
        if (obs_done !== 0) begin
            n_fail++;
            $display("FAIL rstmid_done got %0d want 0", obs_done);
        end
        if (obs_err !== 0) begin
            n_fail++;
            $display("FAIL rstmid_err got %0d want 0", obs_err);
        end
        if (obs_high[0] + obs_high[1] + obs_high[2] + obs_high[3] !== 0) begin
            n_fail++;
            $display("FAIL rstmid_active_cleared got %0d want 0", obs_high[0] + obs_high[1] + obs_high[2] + obs_high[3]);
        end
        clear_obs();
        send_frame(2'd3, 4'd6, 1'b0);
        next_period();
        clear_obs();
        repeat (PERIOD) step(1'b0);
        n_checks++;
        if (obs_high[3] !== exp_high(6)) begin
            n_fail++;
            $display("FAIL rstmid_next_frame got %0d want %0d", obs_high[3], exp_high(6));
        end
    endtask

    task automatic test_random();
        int want_done, want_err;
        logic [1:0]    idx;
        logic [CW-1:0] val;
        logic          stp;
        want_done = 0;
        want_err  = 0;
        clear_obs();
        for (int f = 0; f < 30; f++) begin
            idx = 2'($urandom_range(0, NUM_CH - 1));
            val = CW'($urandom_range(0, MAXV));
            stp = ($urandom_range(0, 3) == 0);
            if (stp) want_err++;
            else want_done++;
            send_frame(idx, val, stp);
            repeat ($urandom_range(0, 20)) step(1'b0);
        end
        next_period();
        repeat (PERIOD) step(1'b0);
        n_checks += 2;
        if (obs_done !== want_done) begin
            n_fail++;
            $display("FAIL random_done_count got %0d want %0d", obs_done, want_done);
        end
        if (obs_err !== want_err) begin
            n_fail++;
            $display("FAIL random_err_count got %0d want %0d", obs_err, want_err);
        end
    endtask

`ifdef PPWM_CENTER_ALIGN_EN
    task automatic test_center();
        send_frame(2'd3, 4'd4, 1'b0);
        next_period();
        clear_obs();
        repeat (PERIOD) step(1'b0);
        n_checks++;
        if (obs_high[3] !== 7) begin
            n_fail++;
            $display("FAIL center_duty got %0d want 7", obs_high[3]);
        end
    endtask
`endif

    initial begin
        rst    = 1'b1;
        data_i = 1'b0;
        model_reset();
        clear_obs();
        test_reset();
        test_single_frame();
        test_err_back_to_back();
        test_mid_period();
        test_rst_mid_frame();
        test_random();
`ifdef PPWM_CENTER_ALIGN_EN
        test_center();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
